// File: rtl/hash_bucket_stage_pkg.sv
// Shared defaults, CRC32 constant and the stage word layout for the hash bucket front-end.
package hash_bucket_stage_pkg;

  localparam string       DEF_HASH_TYPE    = "crc32";
  localparam int unsigned DEF_KEY_WIDTH    = 32;
  localparam int unsigned DEF_BUCKET_WIDTH = 8;
  localparam int unsigned DEF_META_WIDTH   = 16;

  // Normal (non-reflected) CRC-32 generator polynomial
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

  // Word carried through the delay pipeline at default widths, key in the MSBs
  typedef struct packed {
    logic [DEF_KEY_WIDTH-1:0]    key;
    logic [DEF_META_WIDTH-1:0]   meta;
    logic [DEF_BUCKET_WIDTH-1:0] bucket;
  } stage_word_t;

  localparam int unsigned STAGE_WORD_WIDTH = $bits(stage_word_t);

endpackage

// File: rtl/crc32_d32_comb.sv
// Combinational CRC-32 of a 32-bit word: (key * x^32) mod P, MSB first, zero init, no final XOR.
module crc32_d32_comb
  import hash_bucket_stage_pkg::*;
(
  input  logic [31:0] key_i,
  output logic [31:0] crc_o
);

  logic [31:0] acc;

  // Bit-serial recurrence unrolled into an XOR tree
  always_comb begin
    acc = '0;
    for (int i = 31; i >= 0; i--) begin
      acc = {acc[30:0], 1'b0} ^ ({32{acc[31] ^ key_i[i]}} & CRC32_POLY);
    end
  end

  assign crc_o = acc;

endmodule

// File: rtl/ht_pipe_delay.sv
// Generic valid/ready register chain of DELAY stages; plain stages or 2-entry skid stages.
module ht_pipe_delay #(
  parameter int unsigned D_WIDTH        = 8,
  parameter int unsigned DELAY          = 1,
  parameter int unsigned PIPELINE_READY = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [D_WIDTH-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  if (DELAY < 1) begin : g_bad_delay
    $error("ht_pipe_delay: DELAY must be >= 1");
  end

  if (PIPELINE_READY == 0) begin : g_comb
    logic [DELAY-1:0]   v_q;
    logic [D_WIDTH-1:0] d_q    [DELAY];
    logic [DELAY-1:0]   up_v_c;
    logic [D_WIDTH-1:0] up_d_c [DELAY];
    logic [DELAY:0]     rdy_c;

    // Upstream feed of each stage: input port for stage 0, previous stage otherwise
    always_comb begin
      up_v_c    = '0;
      up_d_c    = '{default: '0};
      up_v_c[0] = valid_i;
      up_d_c[0] = data_i;
      for (int i = 1; i < int'(DELAY); i++) begin
        up_v_c[i] = v_q[i-1];
        up_d_c[i] = d_q[i-1];
      end
    end

    // Ready ripples back from the output: a stage accepts when empty or draining
    always_comb begin
      rdy_c        = '0;
      rdy_c[DELAY] = ready_i;
      for (int i = int'(DELAY) - 1; i >= 0; i--) begin
        rdy_c[i] = !v_q[i] || rdy_c[i+1];
      end
    end

    // Stage registers load whenever their ready is high; data only on a valid word
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        v_q <= '0;
        d_q <= '{default: '0};
      end else begin
        for (int i = 0; i < int'(DELAY); i++) begin
          if (rdy_c[i]) begin
            v_q[i] <= up_v_c[i];
            if (up_v_c[i]) d_q[i] <= up_d_c[i];
          end
        end
      end
    end

    assign ready_o = rdy_c[0];
    assign valid_o = v_q[DELAY-1];
    assign data_o  = d_q[DELAY-1];

  end else begin : g_skid
    logic [DELAY-1:0]   ov_q, sv_q, rdy_q;
    logic [DELAY-1:0]   ov_n, sv_n, rdy_n;
    logic [DELAY-1:0]   up_v_c, dn_rdy_c, up_fire_c;
    logic [D_WIDTH-1:0] od_q [DELAY];
    logic [D_WIDTH-1:0] sd_q [DELAY];
    logic [D_WIDTH-1:0] od_n [DELAY];
    logic [D_WIDTH-1:0] sd_n [DELAY];
    logic [D_WIDTH-1:0] up_d_c [DELAY];

    // Neighbour wiring: upstream word and registered downstream ready per stage
    always_comb begin
      up_v_c              = '0;
      up_d_c              = '{default: '0};
      dn_rdy_c            = '0;
      up_v_c[0]           = valid_i;
      up_d_c[0]           = data_i;
      dn_rdy_c[DELAY-1]   = ready_i;
      for (int i = 1; i < int'(DELAY); i++) begin
        up_v_c[i]     = ov_q[i-1];
        up_d_c[i]     = od_q[i-1];
        dn_rdy_c[i-1] = rdy_q[i];
      end
    end

    // Skid next state: output slot refills from skid first, skid catches words during a stall
    always_comb begin
      ov_n      = ov_q;
      sv_n      = sv_q;
      od_n      = od_q;
      sd_n      = sd_q;
      up_fire_c = up_v_c & rdy_q;
      for (int i = 0; i < int'(DELAY); i++) begin
        if (!ov_q[i] || dn_rdy_c[i]) begin
          if (sv_q[i]) begin
            ov_n[i] = 1'b1;
            od_n[i] = sd_q[i];
            sv_n[i] = 1'b0;
          end else begin
            ov_n[i] = up_fire_c[i];
            if (up_fire_c[i]) od_n[i] = up_d_c[i];
          end
        end else if (up_fire_c[i]) begin
          sv_n[i] = 1'b1;
          sd_n[i] = up_d_c[i];
        end
      end
      rdy_n = ~sv_n;
    end

    // Skid state registers; ready stays low during reset and rises on the first edge after
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        ov_q  <= '0;
        sv_q  <= '0;
        rdy_q <= '0;
        od_q  <= '{default: '0};
        sd_q  <= '{default: '0};
      end else begin
        ov_q  <= ov_n;
        sv_q  <= sv_n;
        rdy_q <= rdy_n;
        od_q  <= od_n;
        sd_q  <= sd_n;
      end
    end

    assign ready_o = rdy_q[0];
    assign valid_o = ov_q[DELAY-1];
    assign data_o  = od_q[DELAY-1];
  end

endmodule

// File: rtl/hash_bucket_stage.sv
// Hash-table front-end: hashes the key into a bucket index and pipelines {key, meta, bucket}.
module hash_bucket_stage
  import hash_bucket_stage_pkg::*;
#(
  parameter string       HASH_TYPE      = DEF_HASH_TYPE,
  parameter int unsigned KEY_WIDTH      = DEF_KEY_WIDTH,
  parameter int unsigned BUCKET_WIDTH   = DEF_BUCKET_WIDTH,
  parameter int unsigned META_WIDTH     = DEF_META_WIDTH,
  parameter int unsigned DELAY          = 1,
  parameter int unsigned PIPELINE_READY = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [KEY_WIDTH-1:0]    key_i,
  input  logic [META_WIDTH-1:0]   meta_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [KEY_WIDTH-1:0]    key_o,
  output logic [META_WIDTH-1:0]   meta_o,
  output logic [BUCKET_WIDTH-1:0] bucket_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int unsigned WORD_WIDTH = KEY_WIDTH + META_WIDTH + BUCKET_WIDTH;

  logic [BUCKET_WIDTH-1:0] bucket_c;
  logic [WORD_WIDTH-1:0]   word_in_c;
  logic [WORD_WIDTH-1:0]   word_out;

  if (BUCKET_WIDTH < 1 || BUCKET_WIDTH > 32 || BUCKET_WIDTH > KEY_WIDTH) begin : g_bad_bw
    $error("hash_bucket_stage: BUCKET_WIDTH out of range");
  end

  // Hash selection: CRC32 top bits, or key low bits for bring-up
  if (HASH_TYPE == "crc32") begin : g_crc
    logic [31:0] crc_c;
    logic        unused_crc_bits;

    if (KEY_WIDTH != 32) begin : g_bad_kw
      $error("hash_bucket_stage: crc32 requires KEY_WIDTH == 32");
    end

    crc32_d32_comb u_crc (
      .key_i (32'(key_i)),
      .crc_o (crc_c)
    );

    assign bucket_c        = crc_c[31 -: BUCKET_WIDTH];
    assign unused_crc_bits = ^crc_c;
  end else if (HASH_TYPE == "dummy") begin : g_dummy
    assign bucket_c = key_i[BUCKET_WIDTH-1:0];
  end else begin : g_bad_hash
    $error("hash_bucket_stage: HASH_TYPE must be \"crc32\" or \"dummy\"");
    assign bucket_c = '0;
  end

  assign word_in_c = {key_i, meta_i, bucket_c};

  ht_pipe_delay #(
    .D_WIDTH        (WORD_WIDTH),
    .DELAY          (DELAY),
    .PIPELINE_READY (PIPELINE_READY)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .data_i  (word_in_c),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (word_out),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  assign {key_o, meta_o, bucket_o} = word_out;

endmodule

// File: tb/tb_hash_bucket_stage.sv
// Scoreboard bench for hash_bucket_stage over four hash/delay/ready-mode configurations.
module tb_hash_bucket_stage;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] key_i    [NDUT];
  logic [15:0] meta_i   [NDUT];
  logic        valid_i  [NDUT];
  logic        ready_o  [NDUT];
  logic [31:0] key_o    [NDUT];
  logic [15:0] meta_o   [NDUT];
  logic [7:0]  bucket_o [NDUT];
  logic        valid_o  [NDUT];
  logic        ready_i  [NDUT];

  always #5 clk = ~clk;

  // 0: crc32 D1 comb-ready, 1: crc32 D3 skid, 2: dummy D3 comb-ready, 3: dummy D1 skid
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    hash_bucket_stage #(
      .HASH_TYPE      ((g < 2) ? "crc32" : "dummy"),
      .KEY_WIDTH      (32),
      .BUCKET_WIDTH   (8),
      .META_WIDTH     (16),
      .DELAY          ((g == 0 || g == 3) ? 1 : 3),
      .PIPELINE_READY (g % 2)
    ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst_n),
      .key_i    (key_i[g]),
      .meta_i   (meta_i[g]),
      .valid_i  (valid_i[g]),
      .ready_o  (ready_o[g]),
      .key_o    (key_o[g]),
      .meta_o   (meta_o[g]),
      .bucket_o (bucket_o[g]),
      .valid_o  (valid_o[g]),
      .ready_i  (ready_i[g])
    );
  end

  int          checks = 0;
  int          errors = 0;
  int          cur = 0;
  logic [55:0] sbq[$];
  bit          in_fire = 1'b0;
  bit          stall_prev = 1'b0;
  logic [56:0] prev_out = '0;
  int          cyc = 0;
  int          nfire = 0;
  int          first_fire = 0;
  int          last_fire = 0;

  logic [31:0] dir_key [4] = '{32'h1, 32'h2, 32'h3, 32'h0};
  logic [7:0]  dir_bkt [4] = '{8'h04, 8'h09, 8'h0D, 8'h00};

  function automatic int dly(input int d);
    return (d == 0 || d == 3) ? 1 : 3;
  endfunction

  function automatic bit skid(input int d);
    return (d % 2) == 1;
  endfunction

  function automatic bit crc_mode(input int d);
    return d < 2;
  endfunction

  // Reference CRC as polynomial long division of key*x^32 by the 33-bit generator
  function automatic logic [31:0] ref_crc(input logic [31:0] k);
    logic [63:0] v;
    logic [63:0] div;
    v   = {k, 32'h0};
    div = {31'h0, 1'b1, 32'h04C11DB7};
    for (int i = 63; i >= 32; i--) begin
      if (v[i]) v = v ^ (div << (i - 32));
    end
    return v[31:0];
  endfunction

  function automatic logic [7:0] exp_bucket(input logic [31:0] k);
    logic [31:0] c;
    c = ref_crc(k);
    if (crc_mode(cur)) return c[31:24];
    return k[7:0];
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h exp %h", tag, cur, got, exp);
    end
  endtask

  // One clock: record input/output handshakes at negedge, compare, return at posedge+1
  task automatic step();
    logic [55:0] w;
    logic [56:0] now_o;
    @(negedge clk);
    in_fire = valid_i[cur] && ready_o[cur];
    if (in_fire) sbq.push_back({key_i[cur], meta_i[cur], exp_bucket(key_i[cur])});
    now_o = {valid_o[cur], key_o[cur], meta_o[cur], bucket_o[cur]};
    if (stall_prev) check_eq("hold", 64'(now_o), 64'(prev_out));
    if (valid_o[cur] && ready_i[cur]) begin
      if (sbq.size() == 0) begin
        check_eq("extra_out", 64'(1), 64'(0));
      end else begin
        w = sbq.pop_front();
        check_eq("word", 64'(now_o[55:0]), 64'(w));
      end
      if (nfire == 0) first_fire = cyc;
      last_fire = cyc;
      nfire++;
    end
    stall_prev = valid_o[cur] && !ready_i[cur];
    prev_out   = now_o;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Drive ready_i; in skid mode ready_o must not move with it
  task automatic set_ready(input bit r);
    logic ro;
    ro = ready_o[cur];
    ready_i[cur] = r;
    #1;
    if (skid(cur)) check_eq("rdy_indep", 64'(ready_o[cur]), 64'(ro));
  endtask

  task automatic run_stream(input int n, input bit rnd);
    int drv;
    int budget;
    drv        = 0;
    budget     = 3000;
    in_fire    = 1'b0;
    stall_prev = 1'b0;
    valid_i[cur] = 1'b0;
    while ((drv < n || (valid_i[cur] && !in_fire) || sbq.size() > 0) && budget > 0) begin
      if (in_fire || !valid_i[cur]) begin
        if (drv < n && (!rnd || $urandom_range(3) != 0)) begin
          valid_i[cur] = 1'b1;
          key_i[cur]   = $urandom;
          meta_i[cur]  = 16'($urandom);
          drv++;
        end else begin
          valid_i[cur] = 1'b0;
        end
      end
      set_ready(rnd ? ($urandom_range(2) != 0) : 1'b1);
      step();
      budget--;
    end
    if (budget == 0) check_eq("timeout", 64'(0), 64'(1));
    check_eq("sb_empty", 64'(sbq.size()), 64'(0));
    valid_i[cur] = 1'b0;
    ready_i[cur] = 1'b1;
  endtask

  // Single word with ready_i high: exact latency and content
  task automatic send_one(input logic [31:0] k, input logic [15:0] m, input logic [7:0] b);
    ready_i[cur] = 1'b1;
    valid_i[cur] = 1'b1;
    key_i[cur]   = k;
    meta_i[cur]  = m;
    @(posedge clk);
    #1;
    valid_i[cur] = 1'b0;
    for (int i = 1; i < dly(cur); i++) begin
      check_eq("lat_early", 64'(valid_o[cur]), 64'(0));
      @(posedge clk);
      #1;
    end
    check_eq("lat_valid", 64'(valid_o[cur]), 64'(1));
    check_eq("bucket", 64'(bucket_o[cur]), 64'(b));
    check_eq("key_meta", 64'({key_o[cur], meta_o[cur]}), 64'({k, m}));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_midstream();
    int pres;
    pres       = 0;
    in_fire    = 1'b0;
    stall_prev = 1'b0;
    valid_i[cur] = 1'b0;
    ready_i[cur] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (in_fire || !valid_i[cur]) begin
        if (pres < 2) begin
          valid_i[cur] = 1'b1;
          key_i[cur]   = $urandom;
          meta_i[cur]  = 16'($urandom);
          pres++;
        end else begin
          valid_i[cur] = 1'b0;
        end
      end
      step();
    end
    check_eq("pre_rst_valid", 64'(valid_o[cur]), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 64'(valid_o[cur]), 64'(0));
    check_eq("rst_data", 64'({key_o[cur], meta_o[cur], bucket_o[cur]}), 64'(0));
    check_eq("rst_ready", 64'(ready_o[cur]), skid(cur) ? 64'(0) : 64'(1));
    sbq.delete();
    valid_i[cur] = 1'b0;
    stall_prev   = 1'b0;
    in_fire      = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_i[cur] = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_ready", 64'(ready_o[cur]), 64'(1));
    run_stream(10, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      valid_i[d] = 1'b0;
      ready_i[d] = 1'b1;
      key_i[d]   = '0;
      meta_i[d]  = '0;
    end
    #12;
    for (int d = 0; d < NDUT; d++) begin
      cur = d;
      check_eq("reset_valid", 64'(valid_o[d]), 64'(0));
      check_eq("reset_data", 64'({key_o[d], meta_o[d], bucket_o[d]}), 64'(0));
      check_eq("reset_ready", 64'(ready_o[d]), skid(d) ? 64'(0) : 64'(1));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      cur = d;
      check_eq("release_ready", 64'(ready_o[d]), 64'(1));
    end

    for (int d = 0; d < NDUT; d++) begin
      cur = d;
      if (crc_mode(d)) begin
        for (int i = 0; i < 4; i++) send_one(dir_key[i], 16'(16'hA000 + i), dir_bkt[i]);
      end else begin
        send_one(32'hDEADBEEF, 16'h1234, 8'hEF);
      end
      run_stream(100, 1'b1);
      nfire = 0;
      run_stream(16, 1'b0);
      check_eq("tp_count", 64'(nfire), 64'(16));
      check_eq("tp_span", 64'(last_fire - first_fire), 64'(15));
      reset_midstream();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
